garage_gate_scheduler: RTL and testbench
========================================

# garage_gate_scheduler

Schedules multiple entry and exit gates of one garage against a single shared occupancy counter. Grants one gate at a time, holds that door open until the car-passed sensor fires or a timeout expires, then closes the door and updates occupancy. It sits between the lane request buttons/sensors and the door actuators. It supersedes per-door direct control when a garage has more than one lane per direction.

## Interface
Parameters:
- MAX_NUM, 10, garage capacity; entry grants are blocked at this occupancy.
- LOG_MAX_NUM, 4, occupancy width; 2^LOG_MAX_NUM > MAX_NUM.
- N_ENTRY, 2, number of entry lanes (≥1).
- N_EXIT, 2, number of exit lanes (≥1).
- DOOR_CYCLES, 4, maximum cycles a door stays open (≥1).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- entry_req  in  N_ENTRY  level request per entry lane; held until served.
- exit_req  in  N_EXIT  level request per exit lane; held until served.
- car_passed  in  1  single-cycle pulse from the door sensor: the car cleared the open door.
- open_entry_door  out  N_ENTRY  one-hot-or-zero entry door command.
- open_exit_door  out  N_EXIT  one-hot-or-zero exit door command.
- occupancy  out  LOG_MAX_NUM  current car count.
- garage_is_complete  out  1  occupancy == MAX_NUM (combinational from occupancy).
- garage_is_empty  out  1  occupancy == 0 (combinational).
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, OPEN, CLOSE.
- IDLE:
  - Eligible entry lanes: entry_req & ~garage_is_complete.
  - Eligible exit lanes: exit_req & ~garage_is_empty.
  - If none are eligible, stay in IDLE.
  - Otherwise select a class, then a lane within it. Assert that lane's door, load timer = 0, go to OPEN.
- Class selection: if both classes are eligible, serve the class not served last; otherwise serve the only eligible class.
- Lane selection: round-robin per class. The pointer moves to granted lane + 1 (mod N) on each grant.
- OPEN:
  - The granted door stays high.
  - car_passed=1: occupancy +1 (entry) or −1 (exit); door drops; go to CLOSE.
  - Otherwise, if timer == DOOR_CYCLES−1: door drops; occupancy unchanged (timeout); go to CLOSE.
  - Otherwise timer +1.
- CLOSE: all doors low for one cycle, then go to IDLE.
- car_passed is ignored in IDLE and CLOSE.
- Deasserting a request during OPEN does not cancel the grant.
- Occupancy cannot overflow or underflow, because eligibility is gated and only one transaction is in flight.

## Timing
- Reset values: doors all 0, occupancy 0, state IDLE, timer 0, both lane pointers 0, last-served class = exit, busy 0, garage_is_empty 1, garage_is_complete 0.
- Reset mid-OPEN closes the door immediately (asynchronously). The in-flight count update is discarded.
- Grant latency: a request high before edge e0 in IDLE gives a door high after e0.
- car_passed sampled at edge e1: door low and occupancy updated after e1; IDLE after e2; next door can open after e3. Minimum grant-to-grant spacing is 3 cycles.
- Timeout: door high for exactly DOOR_CYCLES cycles, then CLOSE.
- car_passed on the timeout edge counts as a pass.
- Doors are registered outputs; at most one door bit across both vectors is ever high.

## Configuration
- Macro: GARAGE_EXIT_PRIORITY_EN.
- Defined: when both classes are eligible, the exit class always wins. Last-served class tracking is unused for selection.
- Undefined: alternating class selection as described in Operation.
- Lane round-robin is identical in both builds.

## Structure
- Shared package garage_pkg:
  - typedef for the state enum {IDLE, OPEN, CLOSE}.
  - typedef for the class enum {CLS_ENTRY, CLS_EXIT}.
- Timer width is derived from DOOR_CYCLES with $clog2, local to the block.
- One sub-module: garage_rr_arbiter, a parameterized N-input round-robin picker.
  - Inputs: req vector, pointer, enable.
  - Output: one-hot grant.
  - Instantiated once for entry lanes and once for exit lanes.

## Test plan
- Reset, then entry_req=2'b01, car_passed one cycle after the door opens → open_entry_door=01 for 1 cycle, occupancy 1, busy low 2 cycles later.
- Both entry lanes held, 4 passes → grants alternate lane0, lane1, lane0, lane1; occupancy 4.
- MAX_NUM=10: fill to 10, then entry_req=11 and exit_req=01 → only the exit door opens; garage_is_complete=1 until the pass, then occupancy 9.
- Entry granted, no car_passed → door high exactly 4 cycles, occupancy unchanged, entry lane re-granted after CLOSE+IDLE.
- Occupancy 3, entry and exit held continuously → classes alternate entry/exit (default build); with GARAGE_EXIT_PRIORITY_EN, all exits are served until occupancy 0, then entries.
- reset_n pulsed low while a door is open → door drops without waiting for clock, occupancy 0, a new request is granted to lane 0 after release.

Source files
------------

// File: rtl/garage_pkg.sv
// Shared types for the garage gate scheduler: controller states
// and the lane class (entry/exit) used for grant bookkeeping.
package garage_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      CLOSE
   } state_t;

   typedef enum logic {
      CLS_ENTRY,
      CLS_EXIT
   } cls_t;

endpackage

// File: rtl/garage_rr_arbiter.sv
// N-input round-robin picker: grants the first requester at or after ptr.
// Ports: req (N), ptr (PW), en; gnt (N) one-hot or zero when en is low.
module garage_rr_arbiter #(
   parameter int N = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt
);

   logic found;

   // k is the distance from the pointer; the nearest requester wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (en && !found && req[i] &&
                i == (int'(ptr) + k) % N) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/garage_gate_scheduler.sv
// Multi-lane garage door scheduler sharing one occupancy counter.
// Grants one entry/exit door at a time, holds it until car_passed or
// timeout, then closes for one cycle and updates occupancy.
// Ports: clock, reset_n, entry_req, exit_req, car_passed in;
// open_entry_door, open_exit_door, occupancy, garage_is_complete,
// garage_is_empty, busy out.
// Build option: GARAGE_EXIT_PRIORITY_EN makes exits win every tie
// between classes instead of alternating.
module garage_gate_scheduler
   import garage_pkg::*;
#(
   parameter int MAX_NUM     = 10,
   parameter int LOG_MAX_NUM = 4,
   parameter int N_ENTRY     = 2,
   parameter int N_EXIT      = 2,
   parameter int DOOR_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [N_ENTRY-1:0]     entry_req,
   input  logic [N_EXIT-1:0]      exit_req,
   input  logic                   car_passed,
   output logic [N_ENTRY-1:0]     open_entry_door,
   output logic [N_EXIT-1:0]      open_exit_door,
   output logic [LOG_MAX_NUM-1:0] occupancy,
   output logic                   garage_is_complete,
   output logic                   garage_is_empty,
   output logic                   busy
);

   localparam int TW  = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam int EPW = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
   localparam int XPW = (N_EXIT > 1) ? $clog2(N_EXIT) : 1;

   state_t                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [EPW-1:0]         eptr_q, eptr_d, eptr_nx;
   logic [XPW-1:0]         xptr_q, xptr_d, xptr_nx;
   cls_t                   last_q, last_d;
   logic [LOG_MAX_NUM-1:0] occ_q, occ_d;
   logic [N_ENTRY-1:0]     edoor_q, edoor_d;
   logic [N_EXIT-1:0]      xdoor_q, xdoor_d;

   logic [N_ENTRY-1:0]     e_elig, e_gnt;
   logic [N_EXIT-1:0]      x_elig, x_gnt;
   logic                   any_e, any_x;
   logic                   pick_x;
   logic                   e_en, x_en;

   assign occupancy          = occ_q;
   assign garage_is_complete = (occ_q == LOG_MAX_NUM'(MAX_NUM));
   assign garage_is_empty    = (occ_q == '0);
   assign busy               = (state_q != IDLE);
   assign open_entry_door    = edoor_q;
   assign open_exit_door     = xdoor_q;

   // Full/empty gating keeps the counter inside 0..MAX_NUM.
   assign e_elig = entry_req & {N_ENTRY{~garage_is_complete}};
   assign x_elig = exit_req & {N_EXIT{~garage_is_empty}};
   assign any_e  = |e_elig;
   assign any_x  = |x_elig;

   always_comb begin
      pick_x = 1'b0;
      if (any_e && any_x) begin
`ifdef GARAGE_EXIT_PRIORITY_EN
         pick_x = 1'b1;
`else
         pick_x = (last_q == CLS_ENTRY);
`endif
      end else begin
         pick_x = any_x;
      end
   end

   assign e_en = (state_q == IDLE) && any_e && !pick_x;
   assign x_en = (state_q == IDLE) && pick_x;

   garage_rr_arbiter #(
      .N (N_ENTRY)
   ) u_entry_arb (
      .req (e_elig),
      .ptr (eptr_q),
      .en  (e_en),
      .gnt (e_gnt)
   );

   garage_rr_arbiter #(
      .N (N_EXIT)
   ) u_exit_arb (
      .req (x_elig),
      .ptr (xptr_q),
      .en  (x_en),
      .gnt (x_gnt)
   );

   // Pointer advances to the lane after the one just granted.
   always_comb begin
      eptr_nx = '0;
      for (int i = 0; i < N_ENTRY; i++) begin
         if (e_gnt[i]) eptr_nx = EPW'((i + 1) % N_ENTRY);
      end
   end

   always_comb begin
      xptr_nx = '0;
      for (int i = 0; i < N_EXIT; i++) begin
         if (x_gnt[i]) xptr_nx = XPW'((i + 1) % N_EXIT);
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      eptr_d  = eptr_q;
      xptr_d  = xptr_q;
      last_d  = last_q;
      occ_d   = occ_q;
      edoor_d = edoor_q;
      xdoor_d = xdoor_q;
      unique case (state_q)
         IDLE: begin
            if (|e_gnt) begin
               edoor_d = e_gnt;
               eptr_d  = eptr_nx;
               last_d  = CLS_ENTRY;
               timer_d = '0;
               state_d = OPEN;
            end else if (|x_gnt) begin
               xdoor_d = x_gnt;
               xptr_d  = xptr_nx;
               last_d  = CLS_EXIT;
               timer_d = '0;
               state_d = OPEN;
            end
         end
         OPEN: begin
            // A pass on the timeout edge still counts.
            if (car_passed) begin
               if (|edoor_q) occ_d = occ_q + LOG_MAX_NUM'(1);
               else          occ_d = occ_q - LOG_MAX_NUM'(1);
               edoor_d = '0;
               xdoor_d = '0;
               state_d = CLOSE;
            end else if (timer_q == TW'(DOOR_CYCLES - 1)) begin
               edoor_d = '0;
               xdoor_d = '0;
               state_d = CLOSE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         CLOSE: begin
            edoor_d = '0;
            xdoor_d = '0;
            state_d = IDLE;
         end
         default: begin
            edoor_d = '0;
            xdoor_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         eptr_q  <= '0;
         xptr_q  <= '0;
         last_q  <= CLS_EXIT;
         occ_q   <= '0;
         edoor_q <= '0;
         xdoor_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         eptr_q  <= eptr_d;
         xptr_q  <= xptr_d;
         last_q  <= last_d;
         occ_q   <= occ_d;
         edoor_q <= edoor_d;
         xdoor_q <= xdoor_d;
      end
   end

endmodule

// File: tb/tb_garage_gate_scheduler.sv
// Self-checking bench for garage_gate_scheduler: directed vector table,
// hand sequences for multi-cycle corners, randomized model comparison.
module tb_garage_gate_scheduler;

   localparam int MAX_NUM = 10;
   localparam int LOGN    = 4;
   localparam int NE      = 2;
   localparam int NX      = 2;
   localparam int DC      = 4;

   logic          clock;
   logic          reset_n;
   logic [NE-1:0] entry_req;
   logic [NX-1:0] exit_req;
   logic          car_passed;
   logic [NE-1:0] open_entry_door;
   logic [NX-1:0] open_exit_door;
   logic [LOGN-1:0] occupancy;
   logic          garage_is_complete;
   logic          garage_is_empty;
   logic          busy;

   int checks = 0;
   int errors = 0;

   garage_gate_scheduler #(
      .MAX_NUM     (MAX_NUM),
      .LOG_MAX_NUM (LOGN),
      .N_ENTRY     (NE),
      .N_EXIT      (NX),
      .DOOR_CYCLES (DC)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .entry_req          (entry_req),
      .exit_req           (exit_req),
      .car_passed         (car_passed),
      .open_entry_door    (open_entry_door),
      .open_exit_door     (open_exit_door),
      .occupancy          (occupancy),
      .garage_is_complete (garage_is_complete),
      .garage_is_empty    (garage_is_empty),
      .busy               (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Transaction-level reference: a garage with a car count, one open
   // door at most, and a door life measured in cycles shown.
   int m_occ;
   int m_phase;   // 0 idle, 1 door open, 2 closing
   bit m_is_x;
   int m_lane;
   int m_shown;
   int m_eptr;
   int m_xptr;
   bit m_last_x;

   function automatic int pick(input int req, input int ptr, input int n);
      for (int k = 0; k < n; k++) begin
         int l;
         l = (ptr + k) % n;
         if (((req >> l) & 1) != 0) return l;
      end
      return 0;
   endfunction

   task automatic m_reset();
      m_occ = 0; m_phase = 0; m_is_x = 0; m_lane = 0;
      m_shown = 0; m_eptr = 0; m_xptr = 0; m_last_x = 1;
   endtask

   task automatic m_step();
      int ee, xe;
      bit tx;
      case (m_phase)
         0: begin
            ee = (m_occ < MAX_NUM) ? int'(entry_req) : 0;
            xe = (m_occ > 0) ? int'(exit_req) : 0;
            if (ee != 0 || xe != 0) begin
               if (ee != 0 && xe != 0) begin
`ifdef GARAGE_EXIT_PRIORITY_EN
                  tx = 1;
`else
                  tx = !m_last_x;
`endif
               end else begin
                  tx = (xe != 0);
               end
               if (tx) begin
                  m_lane = pick(xe, m_xptr, NX);
                  m_xptr = (m_lane + 1) % NX;
               end else begin
                  m_lane = pick(ee, m_eptr, NE);
                  m_eptr = (m_lane + 1) % NE;
               end
               m_is_x = tx; m_last_x = tx;
               m_shown = 1; m_phase = 1;
            end
         end
         1: begin
            if (car_passed) begin
               m_occ += m_is_x ? -1 : 1;
               m_phase = 2;
            end else if (m_shown == DC) begin
               m_phase = 2;
            end else begin
               m_shown++;
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      m_step();
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      m_reset();
   endtask

   task automatic wait_grant(input string nm);
      int n;
      n = 0;
      while (open_entry_door == 0 && open_exit_door == 0 && n < 20) begin
         tick();
         n++;
      end
      if (open_entry_door == 0 && open_exit_door == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no grant within 20 cycles", nm);
      end
   endtask

   task automatic pass_car();
      car_passed = 1'b1;
      tick();
      car_passed = 1'b0;
   endtask

   typedef struct {
      logic [1:0] er, xr;
      logic       cp;
      logic [1:0] ed, xd;
      int         occ;
      logic       bsy;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [1:0] er, input logic [1:0] xr,
                      input logic cp, input logic [1:0] ed,
                      input logic [1:0] xd, input int occ,
                      input logic bsy);
      vec_t v;
      v.er = er; v.xr = xr; v.cp = cp;
      v.ed = ed; v.xd = xd; v.occ = occ; v.bsy = bsy;
      tv.push_back(v);
   endtask

   int cls_exp[6];
   logic [1:0] ed_e, xd_e;

   initial begin
      reset_n = 1'b0;
      entry_req = '0;
      exit_req = '0;
      car_passed = 1'b0;
      m_reset();

      // entry pass, timeout, re-grant, ignored pulses, exits, mixed
      add(2'b01, 2'b00, 0, 2'b01, 2'b00, 0, 1);
      add(2'b01, 2'b00, 1, 2'b00, 2'b00, 1, 1);
      add(2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0);
      add(2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 1);
      add(2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 1);
      add(2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 1);
      add(2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 1);
      add(2'b10, 2'b00, 0, 2'b00, 2'b00, 1, 1);
      add(2'b10, 2'b00, 0, 2'b00, 2'b00, 1, 0);
      add(2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 1);
      add(2'b10, 2'b00, 1, 2'b00, 2'b00, 2, 1);
      add(2'b00, 2'b00, 1, 2'b00, 2'b00, 2, 0);
      add(2'b00, 2'b00, 1, 2'b00, 2'b00, 2, 0);
      add(2'b00, 2'b10, 0, 2'b00, 2'b10, 2, 1);
      add(2'b00, 2'b10, 1, 2'b00, 2'b00, 1, 1);
      add(2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 0);
`ifdef GARAGE_EXIT_PRIORITY_EN
      add(2'b01, 2'b01, 0, 2'b00, 2'b01, 1, 1);
      add(2'b01, 2'b01, 1, 2'b00, 2'b00, 0, 1);
      add(2'b01, 2'b01, 0, 2'b00, 2'b00, 0, 0);
      add(2'b01, 2'b01, 0, 2'b01, 2'b00, 0, 1);
      add(2'b01, 2'b01, 1, 2'b00, 2'b00, 1, 1);
`else
      add(2'b01, 2'b01, 0, 2'b01, 2'b00, 1, 1);
      add(2'b01, 2'b01, 1, 2'b00, 2'b00, 2, 1);
      add(2'b01, 2'b01, 0, 2'b00, 2'b00, 2, 0);
      add(2'b01, 2'b01, 0, 2'b00, 2'b01, 2, 1);
      add(2'b01, 2'b01, 1, 2'b00, 2'b00, 1, 1);
`endif

      #1;
      chk("rst edoor", open_entry_door, 0);
      chk("rst xdoor", open_exit_door, 0);
      chk("rst occ", occupancy, 0);
      chk("rst busy", busy, 0);
      chk("rst empty", garage_is_empty, 1);
      chk("rst full", garage_is_complete, 0);
      do_reset();

      foreach (tv[i]) begin
         entry_req = tv[i].er;
         exit_req = tv[i].xr;
         car_passed = tv[i].cp;
         tick();
         chk($sformatf("vec%0d edoor", i), open_entry_door, tv[i].ed);
         chk($sformatf("vec%0d xdoor", i), open_exit_door, tv[i].xd);
         chk($sformatf("vec%0d occ", i), occupancy, tv[i].occ);
         chk($sformatf("vec%0d busy", i), busy, tv[i].bsy);
      end
      entry_req = '0; exit_req = '0; car_passed = 0;

      // both entry lanes held: lanes alternate
      do_reset();
      entry_req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         wait_grant("rr grant");
         chk($sformatf("rr lane g%0d", g), open_entry_door,
             (g % 2) ? 2 : 1);
         pass_car();
      end
      chk("rr occ", occupancy, 4);
      entry_req = '0;

      // full garage: only exits are served
      do_reset();
      entry_req = 2'b01;
      for (int g = 0; g < MAX_NUM; g++) begin
         wait_grant("fill");
         pass_car();
      end
      chk("full occ", occupancy, MAX_NUM);
      chk("full flag", garage_is_complete, 1);
      entry_req = 2'b11;
      exit_req = 2'b01;
      wait_grant("full exit");
      chk("full edoor", open_entry_door, 0);
      chk("full xdoor", open_exit_door, 1);
      chk("full flag open", garage_is_complete, 1);
      pass_car();
      chk("full after occ", occupancy, MAX_NUM - 1);
      chk("full after flag", garage_is_complete, 0);
      entry_req = '0; exit_req = '0;
      repeat (3) tick();

      // class ordering with both classes held from occupancy 3
`ifdef GARAGE_EXIT_PRIORITY_EN
      cls_exp = '{1, 1, 1, 0, 0, 0};
`else
      cls_exp = '{1, 0, 1, 0, 1, 0};
`endif
      do_reset();
      entry_req = 2'b01;
      for (int g = 0; g < 3; g++) begin
         wait_grant("fill3");
         pass_car();
      end
      exit_req = 2'b01;
      for (int g = 0; g < 6; g++) begin
         wait_grant("cls grant");
         chk($sformatf("cls g%0d", g), (open_exit_door != 0) ? 1 : 0,
             cls_exp[g]);
         pass_car();
      end
      chk("cls occ", occupancy, 3);
      entry_req = '0; exit_req = '0;

      // asynchronous reset with a door open and a pass pending
      do_reset();
      entry_req = 2'b10;
      wait_grant("ar first");
      pass_car();
      entry_req = 2'b01;
      wait_grant("ar second");
      chk("ar open", open_entry_door, 1);
      car_passed = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar door async", open_entry_door, 0);
      chk("ar occ async", occupancy, 0);
      chk("ar busy async", busy, 0);
      car_passed = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      m_reset();
      entry_req = 2'b11;
      wait_grant("ar regrant");
      chk("ar lane0", open_entry_door, 1);
      entry_req = '0;

      // randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit fill;
         fill = ((c / 150) % 2) == 0;
         entry_req = ($urandom_range(0, 9) < (fill ? 8 : 2)) ?
                     2'($urandom_range(1, 3)) : 2'b00;
         exit_req = ($urandom_range(0, 9) < (fill ? 2 : 8)) ?
                    2'($urandom_range(1, 3)) : 2'b00;
         car_passed = ($urandom_range(0, 2) == 0);
         tick();
         ed_e = (m_phase == 1 && !m_is_x) ? 2'(1 << m_lane) : 2'b00;
         xd_e = (m_phase == 1 && m_is_x) ? 2'(1 << m_lane) : 2'b00;
         chk("rnd edoor", open_entry_door, ed_e);
         chk("rnd xdoor", open_exit_door, xd_e);
         chk("rnd occ", occupancy, m_occ);
         chk("rnd busy", busy, m_phase != 0);
         chk("rnd full", garage_is_complete, m_occ == MAX_NUM);
         chk("rnd empty", garage_is_empty, m_occ == 0);
         chk("rnd onehot",
             $countones({open_entry_door, open_exit_door}) <= 1, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
